// File: rtl/pdm_pkg.sv
// pdm_pkg: shared state encoding, default widths and saturating increment for path_delay_monitor
package pdm_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, EVAL, FIN} state_t;
  localparam int CNT_W_DEF = 16;
  localparam int DLY_W_DEF = 8;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= m) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/pdm_sync.sv
// pdm_sync: optional flop chain on the path output, pass-through when STAGES is 0
module pdm_sync #(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  if (STAGES == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = clk ^ rst;
    assign q = d;
  end else begin : g_chain
    logic [STAGES-1:0] sr;
    // shift the path output through the chain, oldest bit drives q
    always_ff @(posedge clk)
      sr <= rst ? '0 : STAGES'({sr, d});
    assign q = sr[STAGES-1];
  end
endmodule

// File: rtl/path_delay_monitor.sv
// path_delay_monitor: launch/capture delay-fault monitor around one path; PDM_FIRST_FAIL_EN adds first-fail capture
module path_delay_monitor
  import pdm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DLY_W = DLY_W_DEF,
  parameter bit PATH_INV = 1'b0,
  parameter int SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_trials,
  input  logic [DLY_W-1:0] capture_cyc,
  input  logic [DLY_W-1:0] settle_cyc,
  output logic             launch_o,
  input  logic             path_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] trial_count,
  output logic [CNT_W-1:0] late_count,
  output logic [CNT_W-1:0] func_count,
`ifdef PDM_FIRST_FAIL_EN
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_valid,
`endif
  output logic             fault_seen
);
  state_t state, state_n;
  logic [CNT_W-1:0] n_lat;
  logic [DLY_W:0] cap_eff, set_eff, cnt, cap_in, set_in;
  logic expected, early_smp, late_smp, path_s, fail_late, fail_early, last;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(32'(v), CNT_W));
  endfunction

  pdm_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(path_i), .q(path_s));

  assign busy = state inside {LAUNCH, WAIT, EVAL};
  assign done = state == FIN;

  // effective sample points (one extra bit so settle never wraps) and trial outcome decode
  always_comb begin
    cap_in = (capture_cyc == '0) ? (DLY_W+1)'(1) : {1'b0, capture_cyc};
    set_in = ({1'b0, settle_cyc} <= cap_in) ? cap_in + (DLY_W+1)'(1) : {1'b0, settle_cyc};
    fail_late = late_smp != expected;
    fail_early = early_smp != expected;
    last = trial_count == n_lat - CNT_W'(1);
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? ((num_trials == '0) ? FIN : LAUNCH) : IDLE;
      LAUNCH:  state_n = WAIT;
      WAIT:    state_n = (cnt == set_eff) ? EVAL : WAIT;
      EVAL:    state_n = last ? FIN : LAUNCH;
      default: state_n = IDLE;
    endcase
  end

  // state register, launch/sample datapath and result counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      launch_o <= 1'b0;
      expected <= 1'b0;
      early_smp <= 1'b0;
      late_smp <= 1'b0;
      cnt <= '0;
      cap_eff <= '0;
      set_eff <= '0;
      n_lat <= '0;
      trial_count <= '0;
      late_count <= '0;
      func_count <= '0;
      fault_seen <= 1'b0;
`ifdef PDM_FIRST_FAIL_EN
      first_fail_idx <= '0;
      first_fail_valid <= 1'b0;
`endif
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: if (start) begin
          n_lat <= num_trials;
          cap_eff <= cap_in;
          set_eff <= set_in;
          trial_count <= '0;
          late_count <= '0;
          func_count <= '0;
          fault_seen <= 1'b0;
`ifdef PDM_FIRST_FAIL_EN
          first_fail_idx <= '0;
          first_fail_valid <= 1'b0;
`endif
        end
        LAUNCH: begin
          launch_o <= ~launch_o;
          expected <= ~launch_o ^ PATH_INV;
          cnt <= (DLY_W+1)'(1);
        end
        WAIT: begin
          cnt <= cnt + (DLY_W+1)'(1);
          if (cnt == cap_eff) early_smp <= path_s;
          if (cnt == set_eff) late_smp <= path_s;
        end
        EVAL: begin
          trial_count <= inc(trial_count);
          if (fail_late) func_count <= inc(func_count);
          else if (fail_early) late_count <= inc(late_count);
          if (fail_late || fail_early) fault_seen <= 1'b1;
`ifdef PDM_FIRST_FAIL_EN
          if ((fail_late || fail_early) && !first_fail_valid) begin
            first_fail_idx <= trial_count;
            first_fail_valid <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_path_delay_monitor.sv
// tb_path_delay_monitor: scoreboard bench driving clean, slow, trojan and faulty path models
module tb_path_delay_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic [15:0] num_trials = '0;
  logic [7:0] capture_cyc = '0;
  logic [7:0] settle_cyc = '0;
  logic [3:0] nt2 = '0;
  logic launch_o, path_i, busy, done, fault_seen;
  logic [15:0] trial_count, late_count, func_count;
  logic launch2, path2, busy2, done2, fs2;
  logic [3:0] tc2, lc2, fc2;
`ifdef PDM_FIRST_FAIL_EN
  logic [15:0] ffi;
  logic ffv;
  logic [3:0] ffi2;
  logic ffv2;
`endif
  logic [15:0] sr;
  logic prev_launch = 1'b0;
  logic ht;
  int dly = 0;
  int tog = 0;
  int tog_base = 0;
  int cyc = 0;
  bit trojan = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int cyc0; int lat; int trials; int late; int func; bit fault; int ffi; bit ffv;
  } exp_t;
  exp_t q_main[$];
  exp_t q_sat[$];

  always #5 clk = ~clk;

  // path model: launch delayed by dly cycles, inverted by the trojan during trials 3..5
  always @(posedge clk) begin
    cyc <= cyc + 1;
    sr <= {sr[14:0], launch_o};
    prev_launch <= launch_o;
    if (launch_o != prev_launch) tog <= tog + 1;
  end
  assign ht = trojan && ((tog - tog_base) inside {[4:6]});
  assign path_i = ((dly == 0) ? launch_o : sr[4'(dly - 1)]) ^ ht;
  assign path2 = ~launch2;

  path_delay_monitor #(.CNT_W(16), .DLY_W(8), .PATH_INV(1'b0), .SYNC_STAGES(0)) dut (
    .clk(clk), .rst(rst), .start(start), .num_trials(num_trials),
    .capture_cyc(capture_cyc), .settle_cyc(settle_cyc), .launch_o(launch_o),
    .path_i(path_i), .busy(busy), .done(done), .trial_count(trial_count),
    .late_count(late_count), .func_count(func_count),
`ifdef PDM_FIRST_FAIL_EN
    .first_fail_idx(ffi), .first_fail_valid(ffv),
`endif
    .fault_seen(fault_seen)
  );

  path_delay_monitor #(.CNT_W(4), .DLY_W(8), .PATH_INV(1'b0), .SYNC_STAGES(0)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .num_trials(nt2),
    .capture_cyc(8'd0), .settle_cyc(8'd0), .launch_o(launch2),
    .path_i(path2), .busy(busy2), .done(done2), .trial_count(tc2),
    .late_count(lc2), .func_count(fc2),
`ifdef PDM_FIRST_FAIL_EN
    .first_fail_idx(ffi2), .first_fail_valid(ffv2),
`endif
    .fault_seen(fs2)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor for the main instance: pops one expectation per done pulse
  initial begin : mon_main
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (q_main.size() == 0) chk("main_unexpected_done", 1, 0);
        else begin
          e = q_main.pop_front();
          chk("main_latency", cyc - e.cyc0, e.lat);
          chk("main_busy_at_done", busy, 0);
          chk("main_trials", trial_count, e.trials);
          chk("main_late", late_count, e.late);
          chk("main_func", func_count, e.func);
          chk("main_fault_seen", fault_seen, e.fault);
`ifdef PDM_FIRST_FAIL_EN
          chk("main_ff_valid", ffv, e.ffv);
          if (e.ffv) chk("main_ff_idx", ffi, e.ffi);
`endif
        end
      end
    end
  end

  // monitor for the narrow-counter instance
  initial begin : mon_sat
    exp_t e;
    forever begin
      @(negedge clk);
      if (done2) begin
        if (q_sat.size() == 0) chk("sat_unexpected_done", 1, 0);
        else begin
          e = q_sat.pop_front();
          chk("sat_latency", cyc - e.cyc0, e.lat);
          chk("sat_trials", tc2, e.trials);
          chk("sat_late", lc2, e.late);
          chk("sat_func", fc2, e.func);
          chk("sat_fault_seen", fs2, e.fault);
`ifdef PDM_FIRST_FAIL_EN
          chk("sat_ff_valid", ffv2, e.ffv);
          chk("sat_ff_idx", ffi2, e.ffi);
`endif
        end
      end
    end
  end

  task automatic wait_empty(input string name, input bit sat);
    int n = 0;
    while (((sat ? q_sat.size() : q_main.size()) != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      chk({name, "_timeout"}, 1, 0);
      q_main.delete();
      q_sat.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_main(input string name, input int nt, input int cap, input int st, input int d,
                          input bit troj, input int lat, input int tr, input int lt, input int fn,
                          input bit fs, input int fi, input bit fv, input bit poke);
    exp_t e;
    @(negedge clk);
    dly = d;
    trojan = troj;
    tog_base = tog;
    num_trials = 16'(nt);
    capture_cyc = 8'(cap);
    settle_cyc = 8'(st);
    start = 1'b1;
    e = '{cyc, lat, tr, lt, fn, fs, fi, fv};
    q_main.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (20) @(negedge clk);
      chk({name, "_busy_mid_run"}, busy, 1);
      num_trials = 16'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_empty(name, 1'b0);
  endtask

  initial begin : stim
    exp_t e;
    logic l0;
    int n;
    repeat (20) @(negedge clk);
    chk("rst_launch", launch_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trials", trial_count, 0);
    chk("rst_late", late_count, 0);
    chk("rst_func", func_count, 0);
    chk("rst_fault", fault_seen, 0);
`ifdef PDM_FIRST_FAIL_EN
    chk("rst_ff_valid", ffv, 0);
`endif
    rst = 1'b0;
    // 12-cycle trials: 1 + 8*12 = 97 cycles from start to done
    run_main("clean", 8, 6, 10, 4, 1'b0, 97, 8, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    run_main("slow", 8, 6, 10, 8, 1'b0, 97, 8, 8, 0, 1'b1, 0, 1'b1, 1'b0);
    run_main("trojan", 8, 6, 10, 4, 1'b1, 97, 8, 0, 3, 1'b1, 3, 1'b1, 1'b0);
    l0 = launch_o;
    run_main("zero", 0, 6, 10, 4, 1'b0, 1, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    chk("zero_launch_kept", launch_o, l0);
    // settle 3 <= capture 6 becomes 7: 9-cycle trials, delay 6 is late but settles
    run_main("forced_settle", 3, 6, 3, 6, 1'b0, 28, 3, 3, 0, 1'b1, 0, 1'b1, 1'b0);
    // capture/settle 0 become 1/2: 4-cycle trials, delay 1 misses early only
    run_main("min_window", 5, 0, 0, 1, 1'b0, 21, 5, 5, 0, 1'b1, 0, 1'b1, 1'b0);
    // abort during trial 4 of 10
    @(negedge clk);
    dly = 4;
    trojan = 1'b0;
    tog_base = tog;
    num_trials = 16'd10;
    capture_cyc = 8'd6;
    settle_cyc = 8'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ((tog - tog_base) < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_trial4", tog - tog_base, 5);
    chk("abort_pre_count", trial_count, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_trials", trial_count, 0);
    chk("abort_launch", launch_o, 0);
    chk("abort_fault", fault_seen, 0);
    repeat (30) @(negedge clk);
    run_main("after_abort", 10, 6, 10, 4, 1'b0, 121, 10, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    // narrow counters on an always-wrong path: 1 + 15*4 = 61 cycles, func stays at 15
    @(negedge clk);
    nt2 = 4'd15;
    start2 = 1'b1;
    e = '{cyc, 61, 15, 0, 15, 1'b1, 0, 1'b1};
    q_sat.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
    wait_empty("sat", 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not terminate");
  end
endmodule
